mem_arbiter: RTL

- Shares one single-port unified memory between the instruction-fetch path (PC side) and the load/store data path of the single-cycle MIPS core.
- Allows one outstanding access at a time and uses a request/grant/valid handshake per requester.
- Drives a stall signal so the core holds the PC and the register-file write while its accesses are pending.
- Sits between the core and the memory model, replacing the separate instruction and data memory ports.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_lat_cnt.sv | 29 ++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory arbiter (mem_arbiter).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    SRC_IF,
    SRC_D
  } src_e;

  // Width of a counter that must hold values 0..lat.
  function automatic int unsigned lat_width(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter used to time the memory latency.
// Saturates at zero; o_zero flags the final wait cycle.
module mem_arb_lat_cnt #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. One access in flight at a time; grant is combinational in
// IDLE/RESP so a held request can issue back-to-back.
// Optional macro MEM_ARB_RR_EN: round-robin on ties instead of data-first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int unsigned CW = lat_width(MEM_LAT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  state_e            r_state;
  state_e            w_next_state;
  src_e              r_src;
  src_e              w_win;
  logic              r_we;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_can_grant;
  logic              w_grant;
  logic              w_pick_d;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

`ifdef MEM_ARB_RR_EN
  src_e r_last_src;

  // On a tie, the source not granted last wins.
  always_comb begin
    w_pick_d = d_req && (!if_req || (r_last_src == SRC_IF));
  end

  // Remember the most recent winner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_src <= SRC_IF;
    end else if (w_grant) begin
      r_last_src <= w_win;
    end
  end
`else
  // Data always beats fetch: a data access belongs to an older instruction.
  always_comb begin
    w_pick_d = d_req;
  end
`endif

  assign w_can_grant = rst && ((r_state == IDLE) || (r_state == RESP));
  assign w_grant     = w_can_grant && (if_req || d_req);
  assign w_win       = w_pick_d ? SRC_D : SRC_IF;

  mem_arb_lat_cnt #(
    .W (CW)
  ) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Next state, grant and memory strobe; address/data pass through on grant.
  always_comb begin
    w_next_state = r_state;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = r_mem_addr;
    mem_wdata    = r_mem_wdata;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        if (w_grant) begin
          mem_en       = 1'b1;
          w_cnt_load   = 1'b1;
          w_next_state = WAIT;
          if (w_win == SRC_D) begin
            d_gnt     = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
          end else begin
            if_gnt    = 1'b1;
            mem_addr  = if_addr;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_zero) begin
          w_next_state = RESP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, latched source and response capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_src       <= SRC_IF;
      r_we        <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_src       <= w_win;
        r_we        <= mem_we;
        r_mem_addr  <= mem_addr;
        r_mem_wdata <= mem_wdata;
      end
      if ((r_state == WAIT) && w_cnt_zero) begin
        if (r_src == SRC_IF) begin
          r_if_rdata <= mem_rdata;
        end else if (!r_we) begin
          r_d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign if_valid = rst && (r_state == RESP) && (r_src == SRC_IF);
  assign d_valid  = rst && (r_state == RESP) && (r_src == SRC_D);
  assign stall    = rst && ((if_req && !if_gnt) || (d_req && !d_gnt) ||
                            (r_state == WAIT));

endmodule
